// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one-outstanding requests to
// instruction memory and buffers returned words with their PCs for decode.
module instr_fetch_queue #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              startPC,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_data,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_REQ, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     data_mem_q [DEPTH];
  logic [31:0]     data_mem_d [DEPTH];
  logic [31:0]     pc_mem_q [DEPTH];
  logic [31:0]     pc_mem_d [DEPTH];
  logic            imem_req_q, imem_req_d;
  logic [31:0]     imem_addr_q, imem_addr_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            enq;
  logic            deq;
  logic            flush;

  // Redirect outranks both queue operations; a head handshake in that cycle still completes.
  assign enq   = (state_q == S_REQ) && imem_ack && !redirect;
  assign flush = redirect && (state_q != S_BOOT);
  assign deq   = instr_valid_q && instr_ready;

  // Queue bookkeeping: circular buffer of {word, pc}, pointers wrap mod DEPTH.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_mem_d = data_mem_q;
    pc_mem_d   = pc_mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        data_mem_d[wr_ptr_q] = imem_data;
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        wr_ptr_d             = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  // Fetch FSM next state, fetch PC and the Moore request/address outputs.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      S_BOOT: begin
        state_d    = S_IDLE;
        fetch_pc_d = redirect ? redirect_pc : startPC;
      end
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_IDLE;
        end else begin
          state_d = (count_q < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_REQ: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_ack ? S_REQ : S_DRAIN;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        // The abandoned address stays on the bus until memory answers; its data is dropped.
        fetch_pc_d = redirect ? redirect_pc : fetch_pc_q;
        state_d    = imem_ack ? S_IDLE : S_DRAIN;
      end
      default: begin
        state_d    = S_BOOT;
        fetch_pc_d = fetch_pc_q;
      end
    endcase
    imem_req_d    = (state_d == S_REQ) || (state_d == S_DRAIN);
    imem_addr_d   = (state_d == S_REQ) ? fetch_pc_d : imem_addr_q;
    instr_valid_d = (count_d != '0);
    instr_d       = data_mem_d[rd_ptr_d];
    instr_pc_d    = pc_mem_d[rd_ptr_d];
  end

  // State, queue and registered output flops.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= 32'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      data_mem_q    <= '{default: 32'd0};
      pc_mem_q      <= '{default: 32'd0};
      imem_req_q    <= 1'b0;
      imem_addr_q   <= 32'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      data_mem_q    <= data_mem_d;
      pc_mem_q      <= pc_mem_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: boot, backpressure, slow memory, redirects, async reset.
module tb_instr_fetch_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] startPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  queue_count;

  logic        ack_auto;
  logic        ack_man;
  int          lat;
  int          wait_cnt;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  always #5 CLK = ~CLK;

  instr_fetch_queue #(.DEPTH(4), .PC_STEP(32'd4)) dut (
    .CLK(CLK), .RESET(RESET), .startPC(startPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .queue_count(queue_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: answers after `lat` waiting cycles, or under manual control.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign imem_ack  = ack_auto ? (imem_req && (wait_cnt >= lat)) : ack_man;
  assign imem_data = imem_req ? mem_word(imem_addr) : 32'd0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] a);
    RESET    = 1'b0;
    startPC  = a;
    redirect = 1'b0;
    step();
    step();
    RESET = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; startPC = 32'h100; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    ack_auto = 1'b1; ack_man = 1'b0; lat = 0;
    #1 RESET = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_count", 32'(queue_count), 32'd0);

    // Boot with ack tied high and decode always ready
    step(); step(); RESET = 1'b1;
    step(); chk("boot_e0_req", 32'(imem_req), 32'd0);
    step(); chk("boot_e1_req", 32'(imem_req), 32'd1);
    chk("boot_e1_addr", imem_addr, 32'h100);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("boot_pc", instr_pc, 32'h100 + 32'(4 * k));
      chk("boot_instr", instr, mem_word(32'h100 + 32'(4 * k)));
      chk("boot_valid", 32'(instr_valid), 32'd1);
    end

    // Backpressure: queue fills, then drains in order and fetch resumes at 0x110
    instr_ready = 1'b0;
    do_reset(32'h100);
    step(); step();
    for (int k = 0; k < 4; k++) step();
    chk("bp_count_full", 32'(queue_count), 32'd4);
    chk("bp_req_drop", 32'(imem_req), 32'd0);
    chk("bp_head", instr_pc, 32'h100);
    step(); step(); step();
    chk("bp_req_held_low", 32'(imem_req), 32'd0);
    chk("bp_count_held", 32'(queue_count), 32'd4);
    instr_ready = 1'b1;
    step(); chk("bp_pc1", instr_pc, 32'h104); chk("bp_count3", 32'(queue_count), 32'd3);
    chk("bp_req_still_low", 32'(imem_req), 32'd0);
    step(); chk("bp_pc2", instr_pc, 32'h108); chk("bp_resume_req", 32'(imem_req), 32'd1);
    chk("bp_resume_addr", imem_addr, 32'h110);
    step(); chk("bp_pc3", instr_pc, 32'h10C);
    step(); chk("bp_pc4", instr_pc, 32'h110); chk("bp_instr4", instr, mem_word(32'h110));

    // Slow memory: ack three cycles after the request
    lat = 3;
    do_reset(32'h100);
    step(); step();
    chk("slow_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("slow_addr_stable", imem_addr, 32'h100);
      chk("slow_wait_valid", 32'(instr_valid), 32'd0);
    end
    step(); chk("slow_valid1", 32'(instr_valid), 32'd1); chk("slow_pc1", instr_pc, 32'h100);
    chk("slow_next_addr", imem_addr, 32'h104);
    step(); chk("slow_drained", 32'(instr_valid), 32'd0);
    step(); step();
    step(); chk("slow_pc2", instr_pc, 32'h104); chk("slow_count", 32'(queue_count), 32'd1);

    // Redirect while the request for 0x10C is pending
    ack_auto = 1'b0; ack_man = 1'b0; instr_ready = 1'b0;
    do_reset(32'h100);
    step(); step();
    ack_man = 1'b1;
    step(); step(); step();
    ack_man = 1'b0;
    chk("rd_count3", 32'(queue_count), 32'd3);
    chk("rd_addr_pending", imem_addr, 32'h10C);
    step(); chk("rd_wait_addr", imem_addr, 32'h10C);
    redirect = 1'b1; redirect_pc = 32'h2000;
    step(); redirect = 1'b0;
    chk("rd_flush_count", 32'(queue_count), 32'd0);
    chk("rd_flush_valid", 32'(instr_valid), 32'd0);
    chk("rd_drain_req", 32'(imem_req), 32'd1);
    chk("rd_drain_addr", imem_addr, 32'h10C);
    step(); chk("rd_drain_hold", imem_addr, 32'h10C);
    ack_man = 1'b1;
    step(); ack_man = 1'b0;
    chk("rd_drained_req", 32'(imem_req), 32'd0);
    chk("rd_drop_valid", 32'(instr_valid), 32'd0);
    step(); chk("rd_new_req", 32'(imem_req), 32'd1);
    chk("rd_new_addr", imem_addr, 32'h2000);
    chk("rd_no_stale", 32'(instr_valid), 32'd0);

    // Redirect, ack and head handshake in the same cycle
    instr_ready = 1'b1; ack_man = 1'b1;
    step(); chk("sim_head", instr_pc, 32'h2000);
    redirect = 1'b1; redirect_pc = 32'h3000;
    step(); redirect = 1'b0; instr_ready = 1'b0;
    chk("sim_count", 32'(queue_count), 32'd0);
    chk("sim_valid", 32'(instr_valid), 32'd0);
    chk("sim_req", 32'(imem_req), 32'd1);
    chk("sim_addr", imem_addr, 32'h3000);
    step(); chk("sim_first_pc", instr_pc, 32'h3000);
    chk("sim_first_instr", instr, mem_word(32'h3000));
    step(); step();
    ack_man = 1'b0;
    chk("mid_count3", 32'(queue_count), 32'd3);
    chk("mid_req", 32'(imem_req), 32'd1);
    chk("mid_addr", imem_addr, 32'h300C);

    // Asynchronous reset in mid-cycle, then restart from 0x40
    #2 RESET = 1'b0; startPC = 32'h40;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_count", 32'(queue_count), 32'd0);
    chk("async_instr", instr, 32'd0);
    chk("async_pc", instr_pc, 32'd0);
    ack_auto = 1'b1; lat = 0; instr_ready = 1'b1;
    step(); RESET = 1'b1;
    step();
    step(); chk("restart_addr", imem_addr, 32'h40);
    chk("restart_req", 32'(imem_req), 32'd1);
    step(); chk("restart_pc", instr_pc, 32'h40);
    chk("restart_instr", instr, mem_word(32'h40));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end. It sits directly upstream of the decode/execute datapath (control unit, register file, ALU) and replaces the bare program-counter-plus-instruction-memory pairing. The block owns the fetch PC and issues one-outstanding requests to a variable-latency instruction memory. It buffers returned words with their PCs in a small circular queue and presents them to decode over a valid/ready handshake. A redirect input flushes the queue and restarts fetch, for branches and jumps.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- PC_STEP, 4, fetch PC increment per instruction (byte addressing)
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- startPC  in  32  boot address, sampled in BOOT state
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  response valid this cycle; may assert in the same cycle as imem_req
- imem_data  in  32  instruction word, valid when imem_ack=1
- instr  out  32  head instruction (opcode [31:27], func [26:23], fields below)
- instr_pc  out  32  PC of head instruction
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decode accepts head when instr_valid&instr_ready
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch address
- queue_count  out  $clog2(DEPTH)+1  entries held

## Operation
- FSM states: BOOT, IDLE, REQ, DRAIN. Outputs are Moore: imem_req=1 in REQ and DRAIN, imem_addr=fetch_pc in REQ and the latched old address in DRAIN.
- BOOT: fetch_pc<=startPC, or redirect_pc if redirect=1. Next state is IDLE.
- IDLE: go to REQ when count<DEPTH.
- REQ, ack, no redirect: enqueue {imem_data, fetch_pc}; fetch_pc+=PC_STEP (32-bit wrap). Stay in REQ if the post-edge count<DEPTH, else go to IDLE.
- REQ, no ack: stay. Address and request are held.
- REQ, redirect with ack: drop the data, flush the queue, fetch_pc<=redirect_pc, go to REQ.
- REQ, redirect without ack: flush, fetch_pc<=redirect_pc, go to DRAIN.
- DRAIN: keep requesting the old address until ack. Drop the data, then go to IDLE.
  - A further redirect in DRAIN only overwrites fetch_pc.
- IDLE, redirect: flush, fetch_pc<=redirect_pc, stay IDLE.
- Queue: circular buffer with read and write pointers mod DEPTH.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Enqueue into a full queue cannot occur, because REQ is entered only with a free slot and dequeue only frees slots.
  - Dequeue while empty is ignored.
- Redirect has priority over enqueue and dequeue. A head handshake in the redirect cycle completes, but the queue is still cleared.

## Timing
- Reset (RESET=0, asynchronous):
  - state=BOOT, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, queue_count=0, pointers=0.
- Leaving reset:
  - Edge E0: BOOT→IDLE.
  - Edge E1: IDLE→REQ.
  - imem_req first high in the cycle after E1.
- Latency: data acked at edge En is visible at instr/instr_valid after En. One cycle from ack to decode.
- Throughput: one instruction per cycle with continuous same-cycle ack and continuous instr_ready.
- Redirect sampled at edge Er: queue_count=0 and instr_valid=0 after Er.
  - The first redirected request is raised the cycle after Er if no request was pending.
  - Otherwise it is raised one cycle after the drained ack.
- Reset asserted mid-request: imem_req drops immediately and the in-flight response is ignored. Memory must tolerate an abandoned request.

## Test plan
- Boot: startPC=0x100, ack tied high, ready high.
  - Required: instr_pc sequence 0x100, 0x104, 0x108… one per cycle from the 4th cycle after reset release, with instr matching memory contents.
- Backpressure: instr_ready=0, ack high.
  - Required: queue_count reaches 4, imem_req drops, no further addresses are issued.
  - After ready=1: order preserved, fetch resumes at 0x110.
- Slow memory: ack 3 cycles after req.
  - Required: imem_addr stable during the wait, one instruction per 4 cycles, count never exceeds DEPTH.
- Redirect with request pending: redirect_pc=0x2000 while req for 0x10C awaits ack.
  - Required: DRAIN holds 0x10C until ack, data 0x10C never appears on instr, next request is 0x2000.
- Simultaneous events: redirect, ack, and instr_valid&instr_ready in the same cycle.
  - Required: queue empty afterwards, acked word dropped, next imem_addr equals redirect_pc.
- Reset mid-operation: RESET low with queue count 3 and req high.
  - Required: outputs reach reset values without a clock edge. Restart from the new startPC=0x40.
